// File: rtl/sync_fifo_ctrl_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_ctrl_param.
// The master side is the user of the FIFO; the slave side is the FIFO itself.
interface sync_fifo_ctrl_param_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PTR_WIDTH = 4
);
    logic                 wr_en_i;
    logic [WIDTH-1:0]     wdata_i;
    logic                 rd_en_i;
    logic [WIDTH-1:0]     rdata_o;
    logic                 full_o;
    logic                 empty_o;
    logic                 almost_full_o;
    logic                 almost_empty_o;
    logic [PTR_WIDTH:0]   count_o;
    logic                 wr_error_o;
    logic                 rd_error_o;

    modport master (
        output wr_en_i, wdata_i, rd_en_i,
        input  rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );

    modport slave (
        input  wr_en_i, wdata_i, rd_en_i,
        output rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );
endinterface

// File: rtl/sync_fifo_ctrl_param.sv
// Single-clock parametrised FIFO: storage array plus controller with
// wrap-bit pointers, registered occupancy/threshold flags, one-cycle error
// pulses and a selectable first-word-fall-through read port.
module sync_fifo_ctrl_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH),
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sync_fifo_ctrl_param_if.slave bus
);

    localparam logic [PTR_WIDTH:0] DEPTH_C = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AF_C    = AF_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AE_C    = AE_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] ONE_C   = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]   mem [DEPTH];

    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0] count_q,  count_d;
    logic               full_q,   full_d;
    logic               empty_q,  empty_d;
    logic               af_q,     af_d;
    logic               ae_q,     ae_d;
    logic               wr_err_q, wr_err_d;
    logic               rd_err_q, rd_err_d;

    logic                 wr_acc;
    logic                 rd_acc;
    logic [PTR_WIDTH-1:0] wr_addr;
    logic [PTR_WIDTH-1:0] rd_addr;

    assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];

    // Accept decisions, next pointers and next-state flags derived from them.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        rd_acc   = bus.rd_en_i & ~empty_q;
        wr_acc   = bus.wr_en_i & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
        if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]) &&
                   (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]);
        af_d     = (count_d >= AF_C);
        ae_d     = (count_d <= AE_C);
        wr_err_d = bus.wr_en_i & full_q & ~rd_acc;
        rd_err_d = bus.rd_en_i & empty_q;
    end

    // Controller state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array write port; reset still blocks a concurrent write.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; pointers alone define which entries are valid.
        if (!rst_i && wr_acc) mem[wr_addr] <= bus.wdata_i;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented combinationally; a pop just advances rd_ptr.
            assign bus.rdata_o = mem[rd_addr];
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q, rdata_d;

            // Registered read: load the head word on an accepted read, else hold.
            always_comb begin
                rdata_d = rdata_q;
                if (rd_acc) rdata_d = mem[rd_addr];
            end

            // Read data register, cleared by reset.
            always_ff @(posedge clk_i) begin
                if (rst_i) rdata_q <= '0;
                else       rdata_q <= rdata_d;
            end

            assign bus.rdata_o = rdata_q;
        end
    endgenerate

    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_full_o  = af_q;
    assign bus.almost_empty_o = ae_q;
    assign bus.count_o        = count_q;
    assign bus.wr_error_o     = wr_err_q;
    assign bus.rd_error_o     = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_ctrl_param.sv
// Directed bench for sync_fifo_ctrl_param: a registered-read instance and an
// FWFT instance, both DEPTH=16, WIDTH=32, with hand-computed expectations.
module tb_sync_fifo_ctrl_param;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;

    logic clk;
    logic rst;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    sync_fifo_ctrl_param_if #(.WIDTH(WIDTH), .PTR_WIDTH(PW)) bus0 ();
    sync_fifo_ctrl_param_if #(.WIDTH(WIDTH), .PTR_WIDTH(PW)) bus1 ();

    sync_fifo_ctrl_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) dut_reg (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    sync_fifo_ctrl_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) dut_fwft (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.wr_en_i = 1'b0;
        bus0.rd_en_i = 1'b0;
        bus0.wdata_i = '0;
    endtask

    task automatic idle1();
        bus1.wr_en_i = 1'b0;
        bus1.rd_en_i = 1'b0;
        bus1.wdata_i = '0;
    endtask

    initial begin
        idle0();
        idle1();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(bus0.count_o), 0);
        check("rst_empty", 32'(bus0.empty_o), 1);
        check("rst_full", 32'(bus0.full_o), 0);
        check("rst_ae", 32'(bus0.almost_empty_o), 1);
        check("rst_af", 32'(bus0.almost_full_o), 0);
        check("rst_rdata", bus0.rdata_o, 0);
        check("rst_wr_err", 32'(bus0.wr_error_o), 0);
        check("rst_rd_err", 32'(bus0.rd_error_o), 0);
        check("rst_fwft_empty", 32'(bus1.empty_o), 1);

        // Fill with 0x1..0x10
        for (int i = 1; i <= 16; i++) begin
            bus0.wr_en_i = 1'b1;
            bus0.wdata_i = 32'(i);
            tick();
            check("fill_count", 32'(bus0.count_o), 32'(i));
            check("fill_empty", 32'(bus0.empty_o), 0);
            if (i == 2)  check("fill_ae_at2", 32'(bus0.almost_empty_o), 1);
            if (i == 3)  check("fill_ae_at3", 32'(bus0.almost_empty_o), 0);
            if (i == 13) check("fill_af_at13", 32'(bus0.almost_full_o), 0);
            if (i == 14) check("fill_af_at14", 32'(bus0.almost_full_o), 1);
            if (i == 15) check("fill_full_at15", 32'(bus0.full_o), 0);
        end
        check("full_flag", 32'(bus0.full_o), 1);
        check("full_count", 32'(bus0.count_o), 16);

        // Overflow write
        bus0.wdata_i = 32'hDEAD;
        tick();
        check("ovf_wr_err", 32'(bus0.wr_error_o), 1);
        check("ovf_count", 32'(bus0.count_o), 16);
        check("ovf_rd_err", 32'(bus0.rd_error_o), 0);
        idle0();
        tick();
        check("ovf_wr_err_pulse", 32'(bus0.wr_error_o), 0);

        // Drain 16
        for (int i = 1; i <= 16; i++) begin
            bus0.rd_en_i = 1'b1;
            tick();
            check("drain_rdata", bus0.rdata_o, 32'(i));
            check("drain_count", 32'(bus0.count_o), 32'(16 - i));
            if (i == 1) check("drain_full_clr", 32'(bus0.full_o), 0);
        end
        check("drain_empty", 32'(bus0.empty_o), 1);

        // Underflow read
        tick();
        check("udf_rd_err", 32'(bus0.rd_error_o), 1);
        check("udf_rdata_hold", bus0.rdata_o, 32'h10);
        check("udf_count", 32'(bus0.count_o), 0);
        idle0();
        tick();
        check("udf_rd_err_pulse", 32'(bus0.rd_error_o), 0);

        // Wrap-around: three rounds of 10 writes then 10 reads
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) begin
                bus0.wr_en_i = 1'b1;
                bus0.wdata_i = 32'(32'h100 + r * 16 + k);
                tick();
                check("wrap_full_never", 32'(bus0.full_o), 0);
            end
            idle0();
            for (int k = 0; k < 10; k++) begin
                bus0.rd_en_i = 1'b1;
                tick();
                check("wrap_rdata", bus0.rdata_o, 32'(32'h100 + r * 16 + k));
            end
            idle0();
            check("wrap_count0", 32'(bus0.count_o), 0);
            check("wrap_empty", 32'(bus0.empty_o), 1);
        end

        // Simultaneous write+read while full
        for (int k = 0; k < 16; k++) begin
            bus0.wr_en_i = 1'b1;
            bus0.wdata_i = 32'(32'h200 + k);
            tick();
        end
        check("sim_full_pre", 32'(bus0.full_o), 1);
        bus0.wr_en_i = 1'b1;
        bus0.rd_en_i = 1'b1;
        bus0.wdata_i = 32'h2FF;
        tick();
        check("sim_full_rdata", bus0.rdata_o, 32'h200);
        check("sim_full_count", 32'(bus0.count_o), 16);
        check("sim_full_wr_err", 32'(bus0.wr_error_o), 0);
        check("sim_full_rd_err", 32'(bus0.rd_error_o), 0);
        check("sim_full_flag", 32'(bus0.full_o), 1);
        idle0();
        for (int k = 1; k <= 16; k++) begin
            bus0.rd_en_i = 1'b1;
            tick();
            check("sim_drain_rdata", bus0.rdata_o, (k == 16) ? 32'h2FF : 32'(32'h200 + k));
        end
        idle0();
        check("sim_drain_empty", 32'(bus0.empty_o), 1);

        // Simultaneous write+read while empty
        bus0.wr_en_i = 1'b1;
        bus0.rd_en_i = 1'b1;
        bus0.wdata_i = 32'h3AA;
        tick();
        check("sim_empty_count", 32'(bus0.count_o), 1);
        check("sim_empty_rd_err", 32'(bus0.rd_error_o), 1);
        check("sim_empty_wr_err", 32'(bus0.wr_error_o), 0);
        check("sim_empty_empty", 32'(bus0.empty_o), 0);
        idle0();
        bus0.rd_en_i = 1'b1;
        tick();
        check("sim_empty_rdata", bus0.rdata_o, 32'h3AA);
        check("sim_empty_count0", 32'(bus0.count_o), 0);
        check("sim_empty_rd_err_clr", 32'(bus0.rd_error_o), 0);
        idle0();

        // FWFT instance
        bus1.wr_en_i = 1'b1;
        bus1.wdata_i = 32'hA5;
        tick();
        idle1();
        check("fwft_empty", 32'(bus1.empty_o), 0);
        check("fwft_rdata", bus1.rdata_o, 32'hA5);
        check("fwft_count", 32'(bus1.count_o), 1);
        tick();
        check("fwft_rdata_hold", bus1.rdata_o, 32'hA5);
        bus1.rd_en_i = 1'b1;
        tick();
        idle1();
        check("fwft_pop_empty", 32'(bus1.empty_o), 1);
        check("fwft_pop_count", 32'(bus1.count_o), 0);
        bus1.wr_en_i = 1'b1;
        bus1.wdata_i = 32'h11;
        tick();
        bus1.wdata_i = 32'h22;
        tick();
        idle1();
        check("fwft_head1", bus1.rdata_o, 32'h11);
        bus1.rd_en_i = 1'b1;
        tick();
        idle1();
        check("fwft_head2", bus1.rdata_o, 32'h22);
        check("fwft_count2", 32'(bus1.count_o), 1);

        // Reset mid-operation
        for (int k = 0; k < 7; k++) begin
            bus0.wr_en_i = 1'b1;
            bus0.wdata_i = 32'(32'h400 + k);
            tick();
        end
        check("mid_count7", 32'(bus0.count_o), 7);
        rst = 1'b1;
        bus0.wdata_i = 32'hBAD;
        tick();
        rst = 1'b0;
        idle0();
        check("mid_rst_count", 32'(bus0.count_o), 0);
        check("mid_rst_empty", 32'(bus0.empty_o), 1);
        check("mid_rst_ae", 32'(bus0.almost_empty_o), 1);
        check("mid_rst_wr_err", 32'(bus0.wr_error_o), 0);
        check("mid_rst_rd_err", 32'(bus0.rd_error_o), 0);
        check("mid_rst_rdata", bus0.rdata_o, 0);
        check("mid_rst_fwft_empty", 32'(bus1.empty_o), 1);
        bus0.wr_en_i = 1'b1;
        bus0.wdata_i = 32'h555;
        tick();
        idle0();
        check("mid_new_count", 32'(bus0.count_o), 1);
        bus0.rd_en_i = 1'b1;
        tick();
        idle0();
        check("mid_new_rdata", bus0.rdata_o, 32'h555);
        check("mid_new_empty", 32'(bus0.empty_o), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl_param.md
Name: sync_fifo_ctrl_param

Overview:
Single-clock, parametrised FIFO (controller plus storage array) that generalises the existing fixed 512x1024 FIFO control.
- Pointers carry an extra wrap bit, which replaces the separate toggle flags.
- Adds registered occupancy count, programmable almost-full/almost-empty thresholds and single-cycle error pulses.
- Adds a selectable first-word-fall-through (FWFT) read mode.
- Used as the generic buffering primitive between producer/consumer stages in the same clock domain.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
PTR_WIDTH, $clog2(DEPTH), address width; internal pointers are PTR_WIDTH+1 bits
AF_THRESH, DEPTH-2, almost_full_o asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on rdata_o while not empty

Ports:
clk_i  in  1  single clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
wr_en_i  in  1  write request
wdata_i  in  WIDTH  write data
rd_en_i  in  1  read request (FWFT=1: acknowledge/pop of head word)
rdata_o  out  WIDTH  read data
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_THRESH
almost_empty_o  out  1  count <= AE_THRESH
count_o  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
wr_error_o  out  1  one-cycle pulse: write rejected
rd_error_o  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst_i=1 at edge):
  - wr_ptr=rd_ptr=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
  - rdata_o=0 (FWFT=0), wr_error_o=rd_error_o=0.
  - Storage array is not cleared.
  - Reset overrides any concurrent wr_en_i/rd_en_i.
  - Reset mid-stream discards all contents; the cycle after reset behaves as an empty FIFO.
- Pointers: wr_ptr/rd_ptr are PTR_WIDTH+1 bits. The low PTR_WIDTH bits address memory; the MSB is the wrap bit. They increment modulo 2*DEPTH, so no explicit DEPTH-1 compare is needed.
- Empty: pointers equal. Full: addresses equal and wrap bits differ. count_o = wr_ptr - rd_ptr (mod 2*DEPTH).
- Write accept: wr_acc = wr_en_i & (!full_o | rd_acc). On accept, mem[wr_addr] <= wdata_i and wr_ptr++.
- Read accept: rd_acc = rd_en_i & !empty_o. On accept, rd_ptr++.
  - FWFT=0: rdata_o <= mem[rd_addr] at the same edge, so data is valid the cycle after the request. rdata_o holds its value when no read is accepted.
  - FWFT=1: rdata_o = mem[rd_addr] combinationally while !empty_o. Value is don't-care when empty; bench checks it only when !empty_o.
- Simultaneous write+read:
  - When full: both are accepted, count stays DEPTH, no wr_error.
  - When empty: the write is accepted; the read is rejected with a rd_error_o pulse (no bypass); count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- Errors:
  - wr_error_o=1 for exactly one cycle after a clock edge where wr_en_i & full_o & !rd_acc.
  - rd_error_o=1 for exactly one cycle after a clock edge where rd_en_i & empty_o.
  - Rejected operations leave pointers, memory and count unchanged.
- Flag timing: all flags and count_o are registered and computed from the next-state count. They reflect the occupancy after the edge at which the operation is accepted (0-cycle lag from the pointer update).
- Thresholds are static. AF_THRESH=DEPTH makes almost_full_o equal full_o; AE_THRESH=0 makes almost_empty_o equal empty_o.

Test Plan:
1. DEPTH=16, WIDTH=32, FWFT=0: reset, then write 0x1..0x10 on 16 consecutive cycles.
   -> Cycle 14: almost_full_o=1 (count=14). After the 16th write: full_o=1, count_o=16.
   -> 17th write (0xDEAD): wr_error_o pulses one cycle, count stays 16.
2. From full, read 16 times.
   -> rdata_o sequence 0x1..0x10, each one cycle after its rd_en_i. empty_o=1 after the last read.
   -> Extra read: rd_error_o pulse, rdata_o holds 0x10.
3. Wrap-around: write 10, read 10, repeat 3 times (crosses address 15->0 and wrap-bit toggle).
   -> Data order preserved, count_o returns to 0 each round, full_o never asserts.
4. Simultaneous cases:
   -> Full with wr_en_i=rd_en_i=1: read returns the oldest word, write accepted, count_o=16, no errors.
   -> Empty with both asserted: count_o=1, rd_error_o=1, wr_error_o=0.
5. FWFT=1: write 0xA5.
   -> rdata_o=0xA5 and empty_o=0 the cycle after the write, with no rd_en_i.
   -> Pop with rd_en_i: empty_o=1 next cycle.
6. Reset mid-operation: fill 7 entries, assert rst_i together with wr_en_i=1.
   -> Next cycle: count_o=0, empty_o=1, almost_empty_o=1, error flags 0.
   -> Subsequent write/read returns the new data, not stale contents.
